// File: rtl/if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage
//
// IF->ID pipeline stage carrying {PC, instruction} pairs with a valid/ready
// handshake. A main register drives the decode side; a skid register absorbs
// the one beat that fetch may still push after decode stalls. This lets fetch
// work from a registered in_ready. A flush drops everything held and presents
// a NOP bubble. A saturating counter records the stalled output cycles.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous kill of all held entries
//   in_valid   in   fetch presents a beat
//   in_ready   out  stage accepts a beat (registered, state only)
//   in_pc      in   PC of incoming instruction
//   in_instr   in   incoming instruction
//   out_valid  out  decode-side beat valid
//   out_ready  in   decode accepts the beat
//   out_pc     out  PC of held instruction
//   out_instr  out  held instruction, NOP_INSTR when not valid
//   stall_cnt  out  saturating count of out_valid & !out_ready cycles
//   stall_clr  in   synchronous clear of stall_cnt
// ---------------------------------------------------------------------------
module if_id_skid_stage #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_clr
);

    // State is encoded by the two valid bits:
    //   EMPTY = !main, FULL = main & !skid, SKID = main & skid
    logic               main_vld_q,   main_vld_d;
    logic               skid_vld_q,   skid_vld_d;
    logic [PC_W-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign in_ready  = ~skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        main_vld_d   = main_vld_q;
        skid_vld_d   = skid_vld_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // Offered beat is dropped; out_pc keeps its last value.
            main_vld_d   = 1'b0;
            skid_vld_d   = 1'b0;
            main_instr_d = NOP_INSTR;
        end else if (!main_vld_q) begin
            if (in_valid) begin
                main_vld_d   = 1'b1;
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end
        end else if (!skid_vld_q) begin
            if (in_valid && out_ready) begin
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end else if (out_ready) begin
                main_vld_d   = 1'b0;
                main_instr_d = NOP_INSTR;
            end else if (in_valid) begin
                // Late beat accepted under registered in_ready goes to skid.
                skid_vld_d   = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end
        end else begin
            if (out_ready) begin
                skid_vld_d   = 1'b0;
                main_pc_d    = skid_pc_q;
                main_instr_d = skid_instr_q;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (main_vld_q && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q   <= 1'b0;
            skid_vld_q   <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            stall_cnt_q  <= '0;
        end else begin
            main_vld_q   <= main_vld_d;
            skid_vld_q   <= skid_vld_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Skid payload is only meaningful while skid_vld_q is set.
    always_ff @(posedge clk) begin
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

endmodule
